video_frame_src: RTL and testbench

Frame-aligned pixel-coordinate source at the head of the video daisy chain, in the `sys_clk` domain. It emits one beat per pixel (x, y, frame/line tags, background colour) for the first core, the bar core. Each beat then passes through the bar, pikachu, pacman and rgb2gray cores and into the line buffer. Generation is gated per frame by a start pulse derived from the display side, which keeps the chain frame-locked to VGA output.

---
 rtl/video_pkg.sv | 26 ++
 rtl/video_xy_counter.sv | 69 ++++++
 rtl/video_frame_src.sv | 114 +++++++++++
 tb/tb_video_frame_src.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: resolution defaults, colour width, the beat
// struct carried along the daisy chain and the source FSM state type.
package video_pkg;

    localparam int VIDEO_H_RES = 640;
    localparam int VIDEO_V_RES = 480;
    localparam int RGB_W       = 12;
    localparam int VIDEO_XW    = $clog2(VIDEO_H_RES);
    localparam int VIDEO_YW    = $clog2(VIDEO_V_RES);

    // One pixel beat as seen by the daisy cores and the line buffer.
    typedef struct packed {
        logic [VIDEO_XW-1:0] x;
        logic [VIDEO_YW-1:0] y;
        logic                sof;
        logic                eol;
        logic                eof;
        logic [RGB_W-1:0]    rgb;
    } pixel_beat_t;

    typedef enum logic {
        SRC_IDLE,
        SRC_STREAM
    } src_state_t;

endpackage

// File: rtl/video_xy_counter.sv
// Raster x/y counter: clear to the origin, advance one pixel per enable,
// wrap at the end of each line and frame, and decode the position tags.
module video_xy_counter
    import video_pkg::*;
#(
    parameter int H_RES = VIDEO_H_RES,
    parameter int V_RES = VIDEO_V_RES,
    localparam int XW = $clog2(H_RES),
    localparam int YW = $clog2(V_RES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          sof,
    output logic          eol,
    output logic          eof
);

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    // Next position: clear wins, otherwise step along the raster with wrap.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // Position registers, reset to the origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Tags decode straight from the registered position.
    always_comb begin
        x   = x_q;
        y   = y_q;
        sof = (x_q == '0) && (y_q == '0);
        eol = (x_q == X_LAST);
        eof = (x_q == X_LAST) && (y_q == Y_LAST);
    end

endmodule

// File: rtl/video_frame_src.sv
// Head of the video daisy chain: waits for a display-side frame start, then
// streams one beat per pixel with valid/ready flow control.
module video_frame_src
    import video_pkg::*;
#(
    parameter int H_RES = VIDEO_H_RES,
    parameter int V_RES = VIDEO_V_RES,
    localparam int XW = $clog2(H_RES),
    localparam int YW = $clog2(V_RES)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             enable,
    input  logic             frame_sync,
    input  logic [RGB_W-1:0] bg_rgb,
    output logic             src_vld,
    input  logic             src_rdy,
    output logic [XW-1:0]    src_x,
    output logic [YW-1:0]    src_y,
    output logic             src_sof,
    output logic             src_eol,
    output logic             src_eof,
    output logic [RGB_W-1:0] src_rgb,
    output logic             frame_done,
    output logic             sync_miss
);

    src_state_t state_q, state_d;

    logic             start;
    logic             accept;
    logic             cnt_eof;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             frame_done_q, frame_done_d;
    logic             sync_miss_q, sync_miss_d;

    video_xy_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_xy (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .clear   (start),
        .advance (accept),
        .x       (src_x),
        .y       (src_y),
        .sof     (src_sof),
        .eol     (src_eol),
        .eof     (cnt_eof)
    );

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= SRC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a frame starts only from idle; leaving happens when the eof beat is taken.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        unique case (state_q)
            SRC_IDLE: begin
                if (frame_sync && enable) begin
                    state_d = SRC_STREAM;
                    start   = 1'b1;
                end
            end
            SRC_STREAM: begin
                if (accept && cnt_eof) begin
                    state_d = SRC_IDLE;
                end
            end
            default: state_d = SRC_IDLE;
        endcase
    end

    // Outputs decoded from state; valid depends only on the state flop.
    always_comb begin
        src_vld    = (state_q == SRC_STREAM);
        accept     = src_vld && src_rdy;
        src_eof    = cnt_eof;
        src_rgb    = rgb_q;
        frame_done = frame_done_q;
        sync_miss  = sync_miss_q;
    end

    // Colour is captured when a beat is loaded, so it holds through stalls.
    always_comb begin
        rgb_d        = rgb_q;
        frame_done_d = accept && cnt_eof;
        sync_miss_d  = frame_sync && (state_q == SRC_STREAM);
        if (start || (accept && !cnt_eof)) begin
            rgb_d = bg_rgb;
        end
    end

    // Colour and pulse registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rgb_q        <= '0;
            frame_done_q <= 1'b0;
            sync_miss_q  <= 1'b0;
        end else begin
            rgb_q        <= rgb_d;
            frame_done_q <= frame_done_d;
            sync_miss_q  <= sync_miss_d;
        end
    end

endmodule

// File: tb/tb_video_frame_src.sv
// Directed bench for video_frame_src on an 8x4 raster with a beat scoreboard.
module tb_video_frame_src;
    import video_pkg::*;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int XW = $clog2(H);
    localparam int YW = $clog2(V);
    localparam int BW = XW + YW + 3 + RGB_W;

    typedef struct {
        int               x;
        int               y;
        logic [RGB_W-1:0] rgb;
    } exp_beat_t;

    logic             sys_clk;
    logic             sys_rst;
    logic             enable;
    logic             frame_sync;
    logic [RGB_W-1:0] bg_rgb;
    logic             src_vld;
    logic             src_rdy;
    logic [XW-1:0]    src_x;
    logic [YW-1:0]    src_y;
    logic             src_sof;
    logic             src_eol;
    logic             src_eof;
    logic [RGB_W-1:0] src_rgb;
    logic             frame_done;
    logic             sync_miss;

    logic [BW-1:0] obs_beat;
    logic [BW-1:0] held_beat;

    exp_beat_t exp_q[$];
    bit        model_busy;
    bit        stall_pending;
    bit        exp_done;
    bit        exp_miss;
    bit        rdy_random;
    bit        rgb_random;
    int        checks;
    int        errors;
    int        cycle;
    int        beats_seen;
    int        done_cnt;
    int        miss_cnt;
    int        last_done_cycle;
    int        b0;
    int        d0;
    int        m0;

    video_frame_src #(
        .H_RES (H),
        .V_RES (V)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .enable     (enable),
        .frame_sync (frame_sync),
        .bg_rgb     (bg_rgb),
        .src_vld    (src_vld),
        .src_rdy    (src_rdy),
        .src_x      (src_x),
        .src_y      (src_y),
        .src_sof    (src_sof),
        .src_eol    (src_eol),
        .src_eof    (src_eof),
        .src_rgb    (src_rgb),
        .frame_done (frame_done),
        .sync_miss  (sync_miss)
    );

    assign obs_beat = {src_x, src_y, src_sof, src_eol, src_eof, src_rgb};

    // Free-running clock, 10 time units per cycle.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Expected beat image, tags worked out from the raster position alone.
    function automatic logic [BW-1:0] packBeat(input exp_beat_t b);
        logic [XW-1:0] xs;
        logic [YW-1:0] ys;
        logic          sof;
        logic          eol;
        logic          eof;
        xs  = XW'(b.x);
        ys  = YW'(b.y);
        sof = (b.x == 0) && (b.y == 0);
        eol = (b.x == H - 1);
        eof = (b.x == H - 1) && (b.y == V - 1);
        return {xs, ys, sof, eol, eof, b.rgb};
    endfunction

    function automatic exp_beat_t makeBeat(input int x, input int y, input logic [RGB_W-1:0] rgb);
        exp_beat_t b;
        b.x   = x;
        b.y   = y;
        b.rgb = rgb;
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fs, input logic en, input logic rst);
        frame_sync = fs;
        enable     = en;
        sys_rst    = rst;
    endtask

    // One clock: run the scoreboard on what is being driven, advance, then check pulses.
    task automatic step();
        exp_beat_t b;
        bit        busy_before;
        bit        start_now;
        bit        eof_now;
        if (rgb_random) bg_rgb = RGB_W'($urandom);
        src_rdy = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
        eof_now = 1'b0;
        if (sys_rst) begin
            exp_q.delete();
            model_busy    = 1'b0;
            stall_pending = 1'b0;
            exp_done      = 1'b0;
            exp_miss      = 1'b0;
        end else begin
            busy_before = model_busy;
            start_now   = frame_sync && enable && !busy_before;
            exp_miss    = frame_sync && busy_before;
            if (stall_pending) checkOutput("stall_hold", 64'(obs_beat), 64'(held_beat));
            if (busy_before && src_rdy) begin
                b = exp_q.pop_front();
                checkOutput("beat", 64'(obs_beat), 64'(packBeat(b)));
                beats_seen++;
                if (b.x == H - 1 && b.y == V - 1) begin
                    eof_now    = 1'b1;
                    model_busy = 1'b0;
                end else if (b.x == H - 1) begin
                    exp_q.push_back(makeBeat(0, b.y + 1, bg_rgb));
                end else begin
                    exp_q.push_back(makeBeat(b.x + 1, b.y, bg_rgb));
                end
            end
            if (start_now) begin
                exp_q.push_back(makeBeat(0, 0, bg_rgb));
                model_busy = 1'b1;
            end
            exp_done      = eof_now;
            stall_pending = busy_before && !src_rdy;
            held_beat     = obs_beat;
        end
        @(posedge sys_clk);
        #1;
        cycle++;
        checkOutput("src_vld", 64'(src_vld), 64'(model_busy));
        checkOutput("frame_done", 64'(frame_done), 64'(exp_done));
        checkOutput("sync_miss", 64'(sync_miss), 64'(exp_miss));
        if (frame_done) begin
            done_cnt++;
            last_done_cycle = cycle;
        end
        if (sync_miss) miss_cnt++;
    endtask

    task automatic startFrame(input logic en);
        applyStimulus(1'b1, en, 1'b0);
        step();
        applyStimulus(1'b0, en, 1'b0);
    endtask

    task automatic waitFor(input int x, input int y, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() > 0 && exp_q[0].x == x && exp_q[0].y == y) begin
                found = 1'b1;
                break;
            end
            step();
        end
        checkOutput("wait_xy", 64'(found), 64'(1));
    endtask

    task automatic runUntilIdle(input int budget);
        for (int i = 0; i < budget && model_busy; i++) step();
        checkOutput("frame_end", 64'(model_busy), 64'(0));
    endtask

    // Directed sequence covering start, stalls, misses, restarts and reset.
    initial begin
        checks = 0; errors = 0; cycle = 0; beats_seen = 0;
        done_cnt = 0; miss_cnt = 0; last_done_cycle = 0;
        model_busy = 0; stall_pending = 0; exp_done = 0; exp_miss = 0;
        rdy_random = 0; rgb_random = 0;
        bg_rgb = '0; src_rdy = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        step();
        step();

        $display("[TB] reset state");
        checkOutput("rst_x", 64'(src_x), 64'(0));
        checkOutput("rst_y", 64'(src_y), 64'(0));
        checkOutput("rst_rgb", 64'(src_rgb), 64'(0));
        checkOutput("rst_tags", 64'({src_sof, src_eol, src_eof}), 64'(3'b100));

        $display("[TB] single frame");
        applyStimulus(1'b0, 1'b1, 1'b0);
        bg_rgb = 12'hA5C;
        while (cycle < 10) step();
        b0 = beats_seen; d0 = done_cnt;
        startFrame(1'b1);
        checkOutput("first_cycle", 64'(cycle), 64'(11));
        checkOutput("first_sof", 64'({src_sof, src_x, src_y}), 64'({1'b1, XW'(0), YW'(0)}));
        runUntilIdle(200);
        checkOutput("beat_count", 64'(beats_seen - b0), 64'(H * V));
        checkOutput("done_cycle", 64'(last_done_cycle), 64'(43));
        checkOutput("done_count", 64'(done_cnt - d0), 64'(1));

        $display("[TB] random backpressure");
        rdy_random = 1; rgb_random = 1;
        b0 = beats_seen; d0 = done_cnt;
        startFrame(1'b1);
        runUntilIdle(2000);
        rdy_random = 0; rgb_random = 0;
        bg_rgb = 12'h3C7;
        checkOutput("bp_beats", 64'(beats_seen - b0), 64'(H * V));
        checkOutput("bp_done", 64'(done_cnt - d0), 64'(1));

        $display("[TB] sync during frame");
        m0 = miss_cnt; d0 = done_cnt;
        startFrame(1'b1);
        waitFor(3, 1, 100);
        startFrame(1'b1);
        runUntilIdle(200);
        repeat (3) step();
        checkOutput("miss_count", 64'(miss_cnt - m0), 64'(1));
        checkOutput("miss_done", 64'(done_cnt - d0), 64'(1));

        $display("[TB] back-to-back frames");
        m0 = miss_cnt; d0 = done_cnt;
        startFrame(1'b1);
        runUntilIdle(200);
        startFrame(1'b1);
        checkOutput("b2b_gap", 64'(cycle - last_done_cycle), 64'(1));
        checkOutput("b2b_sof", 64'(src_sof), 64'(1));
        waitFor(H - 1, V - 1, 100);
        startFrame(1'b1);
        repeat (3) step();
        checkOutput("b2b_done", 64'(done_cnt - d0), 64'(2));
        checkOutput("eof_miss", 64'(miss_cnt - m0), 64'(1));

        $display("[TB] enable drop");
        d0 = done_cnt;
        startFrame(1'b1);
        waitFor(2, 2, 100);
        applyStimulus(1'b0, 1'b0, 1'b0);
        runUntilIdle(200);
        b0 = beats_seen;
        startFrame(1'b0);
        repeat (5) step();
        checkOutput("en_done", 64'(done_cnt - d0), 64'(1));
        checkOutput("en_no_beats", 64'(beats_seen - b0), 64'(0));

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 1'b1, 1'b0);
        startFrame(1'b1);
        waitFor(5, 2, 100);
        d0 = done_cnt;
        applyStimulus(1'b0, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("mid_rst_xy", 64'({src_x, src_y}), 64'(0));
        repeat (3) step();
        checkOutput("mid_rst_done", 64'(done_cnt - d0), 64'(0));
        startFrame(1'b1);
        checkOutput("restart_xy", 64'({src_sof, src_x, src_y}), 64'({1'b1, XW'(0), YW'(0)}));
        runUntilIdle(200);
        checkOutput("restart_done", 64'(done_cnt - d0), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
